// File: rtl/alarm_bank.sv
// N-slot HH:MM alarm bank with ring/snooze/timeout FSM; edits and state changes appear one cycle after the input pulse.
// No backpressure: all button inputs are single-cycle pulses and are acted on in the cycle they arrive.
module alarm_bank #(
    parameter int N_ALARMS       = 4,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [19:0]                 cur_time,
    input  logic                        tick,
    input  logic                        sel_btn,
    input  logic [1:0]                  edit_btns,
    input  logic                        en_btn,
    input  logic                        snooze_btn,
    input  logic                        stop_btn,
    output logic [$clog2(N_ALARMS)-1:0] sel_idx,
    output logic [19:0]                 sel_time,
    output logic [N_ALARMS-1:0]         alarm_en,
    output logic                        ringing,
    output logic                        snoozed,
    output logic [$clog2(N_ALARMS)-1:0] ring_idx
);
    localparam int IW = $clog2(N_ALARMS);

    typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ring_idx_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [12:0]   tgt_q, tgt_d;
    logic [5:0]    slot_hh [N_ALARMS];
    logic [6:0]    slot_mm [N_ALARMS];
    logic          match_any;
    logic [IW-1:0] match_idx;

    function automatic logic [5:0] hour_inc(input logic [5:0] h);
        if (h == 6'h23)
            return 6'h00;
        else if (h[3:0] == 4'd9)
            return {h[5:4] + 2'd1, 4'd0};
        else
            return {h[5:4], h[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] min_inc(input logic [6:0] m);
        if (m == 7'h59)
            return 7'h00;
        else if (m[3:0] == 4'd9)
            return {m[6:4] + 3'd1, 4'd0};
        else
            return {m[6:4], m[3:0] + 4'd1};
    endfunction

    // Done in binary then converted back: simpler than chained BCD carries.
    function automatic logic [12:0] add_snooze(input logic [19:0] t);
        logic [6:0] m;
        logic [4:0] h;
        m = 7'(t[13:11] * 10 + t[10:7]) + 7'(SNOOZE_MIN);
        h = 5'(t[19:18] * 10 + t[17:14]);
        if (m >= 7'd60) begin
            m = m - 7'd60;
            h = h + 5'd1;
        end
        if (h >= 5'd24)
            h = h - 5'd24;
        return {2'(h / 5'd10), 4'(h % 5'd10), 3'(m / 7'd10), 4'(m % 7'd10)};
    endfunction

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int k = N_ALARMS - 1; k >= 0; k--) begin
            if (alarm_en[k] && cur_time == {slot_hh[k], slot_mm[k], 7'd0}) begin
                match_any = 1'b1;
                match_idx = IW'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_idx  <= '0;
            alarm_en <= '0;
            for (int k = 0; k < N_ALARMS; k++) begin
                slot_hh[k] <= '0;
                slot_mm[k] <= '0;
            end
        end else begin
            if (sel_btn)
                sel_idx <= (sel_idx == IW'(N_ALARMS - 1)) ? '0 : sel_idx + 1'b1;
            if (edit_btns[1])
                slot_hh[sel_idx] <= hour_inc(slot_hh[sel_idx]);
            if (edit_btns[0])
                slot_mm[sel_idx] <= min_inc(slot_mm[sel_idx]);
            if (en_btn)
                alarm_en[sel_idx] <= ~alarm_en[sel_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ring_idx <= '0;
            cnt_q    <= '0;
            tgt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ring_idx <= ring_idx_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ring_idx_d = ring_idx;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        case (state_q)
            IDLE: begin
                if (tick && match_any) begin
                    state_d    = RINGING;
                    ring_idx_d = match_idx;
                    cnt_d      = '0;
                end
            end
            RINGING: begin
                if (stop_btn) begin
                    state_d = IDLE;
                end else if (snooze_btn) begin
                    state_d = SNOOZED;
                    tgt_d   = add_snooze(cur_time);
                end else if (tick) begin
                    if (cnt_q + 8'd1 == 8'(RING_TIMEOUT_S))
                        state_d = IDLE;
                    else
                        cnt_d = cnt_q + 8'd1;
                end
            end
            SNOOZED: begin
                if (stop_btn) begin
                    state_d = IDLE;
                end else if (tick && match_any) begin
                    state_d    = RINGING;
                    ring_idx_d = match_idx;
                    cnt_d      = '0;
                end else if (tick && cur_time == {tgt_q, 7'd0}) begin
                    state_d = RINGING;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sel_time = {slot_hh[sel_idx], slot_mm[sel_idx], 7'd0};
    assign ringing  = (state_q == RINGING);
    assign snoozed  = (state_q == SNOOZED);

endmodule

// File: tb/tb_alarm_bank.sv
// Directed bench for alarm_bank (N=4, snooze 5 min, timeout 60 s).
module tb_alarm_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] cur_time;
    logic        tick;
    logic        sel_btn;
    logic [1:0]  edit_btns;
    logic        en_btn;
    logic        snooze_btn;
    logic        stop_btn;
    logic [1:0]  sel_idx;
    logic [19:0] sel_time;
    logic [3:0]  alarm_en;
    logic        ringing;
    logic        snoozed;
    logic [1:0]  ring_idx;

    int tests = 0;
    int fails = 0;

    alarm_bank #(.N_ALARMS(4), .SNOOZE_MIN(5), .RING_TIMEOUT_S(60)) dut (
        .clk(clk), .reset(reset), .cur_time(cur_time), .tick(tick),
        .sel_btn(sel_btn), .edit_btns(edit_btns), .en_btn(en_btn),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn), .sel_idx(sel_idx),
        .sel_time(sel_time), .alarm_en(alarm_en), .ringing(ringing),
        .snoozed(snoozed), .ring_idx(ring_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] t20(input logic [7:0] hh, input logic [7:0] mm, input logic [7:0] ss);
        return {hh[5:0], mm[6:0], ss[6:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs are then returned to idle so pulses last one cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        tick = 0; sel_btn = 0; edit_btns = 2'b00; en_btn = 0; snooze_btn = 0; stop_btn = 0;
    endtask

    task automatic tick_at(input logic [19:0] t);
        cur_time = t;
        tick     = 1;
        cyc();
    endtask

    task automatic edit(input logic [1:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            edit_btns = b;
            cyc();
        end
    endtask

    task automatic sel(input int n);
        for (int i = 0; i < n; i++) begin
            sel_btn = 1;
            cyc();
        end
    endtask

    initial begin
        reset = 1; cur_time = '0; tick = 0; sel_btn = 0; edit_btns = 2'b00;
        en_btn = 0; snooze_btn = 0; stop_btn = 0;
        cyc(); cyc();
        reset = 0;
        chk("rst_sel_time", sel_time, 20'h00000);
        chk("rst_alarm_en", alarm_en, 4'b0000);
        chk("rst_sel_idx", sel_idx, 2'd0);
        chk("rst_ringing", ringing, 1'b0);
        chk("rst_snoozed", snoozed, 1'b0);
        chk("rst_ring_idx", ring_idx, 2'd0);

        sel(1);
        chk("sel_1", sel_idx, 2'd1);
        sel(2);
        chk("sel_3", sel_idx, 2'd3);
        sel(1);
        chk("sel_wrap", sel_idx, 2'd0);

        // Slot 0 up to 23:59, checking the x9 -> (x+1)0 carry on the way.
        edit(2'b11, 10);
        chk("edit_10_10", sel_time, t20(8'h10, 8'h10, 8'h00));
        edit(2'b11, 13);
        edit(2'b01, 36);
        chk("edit_23_59", sel_time, t20(8'h23, 8'h59, 8'h00));
        edit(2'b11, 1);
        chk("edit_wrap_both", sel_time, 20'h00000);

        // Slots 1 and 2 both at 07:30 and enabled.
        sel(1);
        edit(2'b10, 7);
        edit(2'b01, 30);
        chk("slot1_0730", sel_time, t20(8'h07, 8'h30, 8'h00));
        en_btn = 1; cyc();
        sel(1);
        edit(2'b10, 7);
        edit(2'b01, 30);
        en_btn = 1; cyc();
        chk("en_1_2", alarm_en, 4'b0110);
        tick_at(t20(8'h07, 8'h30, 8'h00));
        chk("match_ringing", ringing, 1'b1);
        chk("match_lowest_idx", ring_idx, 2'd1);
        stop_btn = 1; cyc();
        chk("stop_ringing", ringing, 1'b0);

        en_btn = 1; cyc();
        sel(3);
        en_btn = 1; cyc();
        chk("en_cleared", alarm_en, 4'b0000);
        tick_at(t20(8'h07, 8'h30, 8'h00));
        chk("disabled_no_ring", ringing, 1'b0);

        // Slot 0 at 23:58 for the snooze-wrap case.
        sel(3);
        chk("back_to_0", sel_idx, 2'd0);
        edit(2'b10, 23);
        edit(2'b01, 58);
        en_btn = 1; cyc();
        chk("slot0_2358", sel_time, t20(8'h23, 8'h58, 8'h00));
        tick_at(t20(8'h23, 8'h58, 8'h00));
        chk("ring_2358", ringing, 1'b1);
        chk("ring_idx0", ring_idx, 2'd0);
        snooze_btn = 1; cyc();
        chk("snoozed", snoozed, 1'b1);
        chk("snooze_not_ring", ringing, 1'b0);
        tick_at(t20(8'h00, 8'h02, 8'h00));
        chk("snooze_early", snoozed, 1'b1);
        tick_at(t20(8'h00, 8'h03, 8'h00));
        chk("snooze_rering", ringing, 1'b1);
        chk("snooze_same_idx", ring_idx, 2'd0);
        stop_btn = 1; cyc();
        chk("stop_after_rering", ringing, 1'b0);
        tick_at(t20(8'h00, 8'h03, 8'h01));
        chk("idle_no_ring", ringing, 1'b0);

        // Ring timeout: drops exactly on the 60th tick.
        tick_at(t20(8'h23, 8'h58, 8'h00));
        chk("ring_for_timeout", ringing, 1'b1);
        for (int i = 0; i < 59; i++)
            tick_at(t20(8'h23, 8'h58, 8'h01));
        chk("still_ringing_59", ringing, 1'b1);
        tick_at(t20(8'h23, 8'h58, 8'h02));
        chk("timeout_ringing", ringing, 1'b0);
        chk("timeout_snoozed", snoozed, 1'b0);

        // Stop beats snooze.
        tick_at(t20(8'h23, 8'h58, 8'h00));
        chk("ring_again", ringing, 1'b1);
        stop_btn = 1; snooze_btn = 1; cyc();
        chk("stop_wins_ring", ringing, 1'b0);
        chk("stop_wins_snz", snoozed, 1'b0);

        // Reset while snoozed.
        tick_at(t20(8'h23, 8'h58, 8'h00));
        snooze_btn = 1; cyc();
        chk("snoozed_pre_rst", snoozed, 1'b1);
        reset = 1; cyc();
        reset = 0;
        chk("rst2_snoozed", snoozed, 1'b0);
        chk("rst2_ringing", ringing, 1'b0);
        chk("rst2_alarm_en", alarm_en, 4'b0000);
        chk("rst2_sel_time", sel_time, 20'h00000);
        chk("rst2_ring_idx", ring_idx, 2'd0);
        tick_at(t20(8'h00, 8'h03, 8'h00));
        chk("rst2_no_ring", ringing, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
